// File: rtl/apb_engine_pkg.sv
// Shared types and constants for the multi-requester APB engine.
//   apb_state_e  : APB master phase (IDLE / SETUP / ACCESS)
//   ch_width()   : channel-id width for a given client count
//   level_width(): FIFO occupancy width for a given depth
//   PWRITE_*     : APB pwrite encoding
package apb_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic PWRITE_READ  = 1'b0;
   localparam logic PWRITE_WRITE = 1'b1;

   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // One extra bit so that a completely full FIFO (level == depth) is representable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter for the client request channels.
//   clk, reset : clock, synchronous active-high reset
//   valid      : per-channel request valid
//   full       : command FIFO full, suppresses every grant
//   accept     : a granted request was taken this cycle
//   grant      : one-hot (or zero) grant, the first valid channel at or after the pointer
module apb_rr_arbiter
   import apb_engine_pkg::*;
#(
   parameter int  NUM_CH = 4,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] valid,
   input  logic              full,
   input  logic              accept,
   output logic [NUM_CH-1:0] grant
);

   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] grant_idx;
   logic [CH_W-1:0] idx;
   logic            found;

   // Search upward from the pointer with wrap; the first valid channel wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      found     = 1'b0;
      if (!full) begin
         for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!found && valid[idx]) begin
               found       = 1'b1;
               grant[idx]  = 1'b1;
               grant_idx   = idx;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/apb_multi_req_engine.sv
// Multi-client APB3 master front-end.
// Clients raise requests on NUM_CH channels; a round-robin arbiter pushes accepted
// commands into a DEPTH-entry FIFO, and the FSM below drains the FIFO onto one APB3
// master port with wait-state, PSLVERR and timeout handling. Every transfer that is
// completed or aborted produces a one-cycle tagged response.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid_i/rnw_i       : per-channel request valid and direction (1 = read)
//   req_addr_i/wdata_i      : per-channel address / write data, channel k at [k*W +: W]
//   req_ready_o             : one-hot accept strobe
//   psel_o ... pwdata_o     : APB master outputs
//   pready_i/pslverr_i/prdata_i : APB slave responses
//   rsp_*                   : response strobe, channel id, direction, error, read data
//   fifo_level_o            : registered command FIFO occupancy
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus idle; pops the FIFO head when one is waiting
// ST_SETUP  | psel high for one cycle, timeout counter loaded
// ST_ACCESS | psel+penable high until pready, or until the timeout expires
module apb_multi_req_engine
   import apb_engine_pkg::*;
#(
   parameter int  NUM_CH  = 4,
   parameter int  ADDR_W  = 32,
   parameter int  DATA_W  = 32,
   parameter int  DEPTH   = 16,
   parameter int  TIMEOUT = 16,
   localparam int CH_W    = ch_width(NUM_CH),
   localparam int LVL_W   = level_width(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid_i,
   input  logic [NUM_CH-1:0]        req_rnw_i,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
   output logic [NUM_CH-1:0]        req_ready_o,
   output logic                     psel_o,
   output logic                     penable_o,
   output logic                     pwrite_o,
   output logic [ADDR_W-1:0]        paddr_o,
   output logic [DATA_W-1:0]        pwdata_o,
   input  logic                     pready_i,
   input  logic                     pslverr_i,
   input  logic [DATA_W-1:0]        prdata_i,
   output logic                     rsp_valid_o,
   output logic [CH_W-1:0]          rsp_id_o,
   output logic                     rsp_rnw_o,
   output logic                     rsp_err_o,
   output logic [DATA_W-1:0]        rsp_data_o,
   output logic [LVL_W-1:0]         fifo_level_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // ---------------- arbitration ----------------
   logic [NUM_CH-1:0] grant;
   logic              accept;
   logic              full;
   logic              empty;
   logic              pop;

   apb_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .valid  (req_valid_i),
      .full   (full),
      .accept (accept),
      .grant  (grant)
   );

   assign accept      = |(req_valid_i & grant);
   assign req_ready_o = grant;

   logic [CH_W-1:0]   push_id;
   logic              push_rnw;
   logic [ADDR_W-1:0] push_addr;
   logic [DATA_W-1:0] push_wdata;

   always_comb begin
      push_id    = '0;
      push_rnw   = 1'b0;
      push_addr  = '0;
      push_wdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (grant[k]) begin
            push_id    = CH_W'(k);
            push_rnw   = req_rnw_i[k];
            push_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
            push_wdata = req_wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------- command FIFO ----------------
   logic [CH_W-1:0]   fifo_id    [DEPTH];
   logic              fifo_rnw   [DEPTH];
   logic [ADDR_W-1:0] fifo_addr  [DEPTH];
   logic [DATA_W-1:0] fifo_wdata [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;

   // Full comes from the registered level, so a same-cycle pop never frees a slot early.
   assign full         = (level == LVL_W'(DEPTH));
   assign empty        = (level == '0);
   assign fifo_level_o = level;

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_id[wr_ptr]    <= push_id;
         fifo_rnw[wr_ptr]   <= push_rnw;
         fifo_addr[wr_ptr]  <= push_addr;
         fifo_wdata[wr_ptr] <= push_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // ---------------- APB FSM ----------------
   apb_state_e      state;
   apb_state_e      state_nx;
   logic [CH_W-1:0] cur_id;
   logic            cur_rnw;
   logic [TO_W-1:0] to_cnt;
   logic            timeout_hit;
   logic            complete;
   logic            abort;

   assign cur_rnw     = (pwrite_o == PWRITE_READ);
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt == '0);
   assign psel_o      = (state != ST_IDLE);
   assign penable_o   = (state == ST_ACCESS);

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      complete = 1'b0;
      abort    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = ST_SETUP;
            end
         end
         ST_SETUP: state_nx = ST_ACCESS;
         ST_ACCESS: begin
            if (pready_i) begin
               complete = 1'b1;
               // Back-to-back: the next command's SETUP follows without an idle cycle.
               if (!empty) begin
                  pop      = 1'b1;
                  state_nx = ST_SETUP;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else if (timeout_hit) begin
               abort    = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         paddr_o  <= '0;
         pwrite_o <= 1'b0;
         pwdata_o <= '0;
         cur_id   <= '0;
         to_cnt   <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            paddr_o  <= fifo_addr[rd_ptr];
            pwrite_o <= fifo_rnw[rd_ptr] ? PWRITE_READ : PWRITE_WRITE;
            pwdata_o <= fifo_rnw[rd_ptr] ? '0 : fifo_wdata[rd_ptr];
            cur_id   <= fifo_id[rd_ptr];
         end
         // Down-counter: loaded in SETUP, the transfer aborts when it sits at zero in ACCESS.
         if (state == ST_SETUP) begin
            to_cnt <= TO_LOAD;
         end else if (state == ST_ACCESS && !pready_i && to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
         end
      end
   end

   // ---------------- response ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_o <= 1'b0;
         rsp_id_o    <= '0;
         rsp_rnw_o   <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
      end else begin
         rsp_valid_o <= complete | abort;
         if (complete) begin
            rsp_id_o   <= cur_id;
            rsp_rnw_o  <= cur_rnw;
            rsp_err_o  <= pslverr_i;
            rsp_data_o <= (cur_rnw && !pslverr_i) ? prdata_i : '0;
         end else if (abort) begin
            rsp_id_o   <= cur_id;
            rsp_rnw_o  <= cur_rnw;
            rsp_err_o  <= 1'b1;
            rsp_data_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_multi_req_engine.sv
module tb_apb_multi_req_engine;

   localparam int NCH     = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 16;
   localparam int PH_IDLE   = 0;
   localparam int PH_SETUP  = 1;
   localparam int PH_ACCESS = 2;

   typedef struct {
      int          id;
      bit          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      logic [NCH-1:0] valid;
      logic [NCH-1:0] ready;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    req_valid = '0;
   logic [NCH-1:0]    req_rnw = '0;
   logic [NCH*AW-1:0] req_addr = '0;
   logic [NCH*DW-1:0] req_wdata = '0;
   logic [NCH-1:0]    req_ready;
   logic              psel, penable, pwrite;
   logic [AW-1:0]     paddr;
   logic [DW-1:0]     pwdata;
   logic              pready = 1'b0;
   logic              pslverr = 1'b0;
   logic [DW-1:0]     prdata = '0;
   logic              rsp_valid, rsp_rnw, rsp_err;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_data;
   logic [4:0]        fifo_level;

   always #5 clk = ~clk;

   apb_multi_req_engine #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_rnw_i(req_rnw), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_ready_o(req_ready),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata),
      .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rnw_o(rsp_rnw),
      .rsp_err_o(rsp_err), .rsp_data_o(rsp_data), .fifo_level_o(fifo_level)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_rsp = 0;

   // reference model: queue of accepted commands plus the APB phase of the transfer on the bus
   cmd_t          mq[$];
   cmd_t          cur;
   int            ph = PH_IDLE;
   int            mptr = 0;
   int            acc = 0;
   int            cur_waits = 0;
   bit            cur_err = 0;
   logic [DW-1:0] cur_rdata = '0;
   bit            rsp_pend = 0;
   int            r_id = 0;
   bit            r_rnw = 0, r_err = 0;
   logic [DW-1:0] r_data = '0;

   // slave behaviour for the next transfer; waits < 0 means pready never rises
   int            slave_waits = 0;
   bit            slave_err = 0;
   bit            slave_rand = 0;
   logic [DW-1:0] slave_rdata = '0;

   logic [NCH-1:0] s_ready;
   logic           s_psel, s_penable, s_pwrite, s_rsp_valid, s_rsp_rnw, s_rsp_err;
   logic [1:0]     s_rsp_id;
   logic [DW-1:0]  s_rsp_data, s_pwdata;
   logic [AW-1:0]  s_paddr;
   logic [4:0]     s_level;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int ch, input bit rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_rnw[ch]            = rnw;
      req_addr[ch*AW +: AW]  = a;
      req_wdata[ch*DW +: DW] = d;
   endtask

   task automatic start_next();
      cur = mq.pop_front();
      ph  = PH_SETUP;
      if (slave_rand) begin
         cur_waits = int'($urandom_range(0, 3));
         cur_err   = ($urandom_range(0, 5) == 0);
         cur_rdata = $urandom;
      end else begin
         cur_waits = slave_waits;
         cur_err   = slave_err;
         cur_rdata = slave_rdata;
      end
   endtask

   task automatic model_step();
      int             q0;
      logic [NCH-1:0] exp_ready;
      bit             found;
      int             k;
      int             gk;
      cmd_t           c;
      q0 = mq.size();
      chk("psel", psel, ph != PH_IDLE);
      chk("penable", penable, ph == PH_ACCESS);
      if (ph != PH_IDLE) begin
         chk("paddr", paddr, cur.addr);
         chk("pwrite", pwrite, !cur.rnw);
         chk("pwdata", pwdata, cur.rnw ? '0 : cur.wdata);
      end
      exp_ready = '0;
      found = 0;
      gk = 0;
      if (q0 < DEPTH) begin
         for (int i = 0; i < NCH; i++) begin
            k = (mptr + i) % NCH;
            if (!found && req_valid[k]) begin
               found = 1;
               gk = k;
               exp_ready[k] = 1'b1;
            end
         end
      end
      chk("req_ready", req_ready, exp_ready);
      chk("fifo_level", fifo_level, q0);
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (rsp_pend) begin
         chk("rsp_id", rsp_id, r_id);
         chk("rsp_rnw", rsp_rnw, r_rnw);
         chk("rsp_err", rsp_err, r_err);
         chk("rsp_data", rsp_data, r_data);
      end
      rsp_pend = 0;
      case (ph)
         PH_IDLE: if (q0 > 0) start_next();
         PH_SETUP: begin ph = PH_ACCESS; acc = 0; end
         default: begin
            if (pready) begin
               rsp_pend = 1; r_id = cur.id; r_rnw = cur.rnw; r_err = pslverr;
               r_data = (cur.rnw && !pslverr) ? prdata : '0;
               if (q0 > 0) start_next(); else ph = PH_IDLE;
            end else begin
               acc++;
               if (TIMEOUT != 0 && acc == TIMEOUT) begin
                  rsp_pend = 1; r_id = cur.id; r_rnw = cur.rnw; r_err = 1; r_data = '0;
                  ph = PH_IDLE;
               end
            end
         end
      endcase
      if (found) begin
         c.id = gk; c.rnw = req_rnw[gk];
         c.addr = req_addr[gk*AW +: AW]; c.wdata = req_wdata[gk*DW +: DW];
         mq.push_back(c);
         mptr = (gk + 1) % NCH;
      end
   endtask

   // one clock cycle: drive slave, settle, snapshot, check/advance model, clock edge
   task automatic tick();
      if (!reset && ph == PH_ACCESS && cur_waits >= 0 && acc >= cur_waits) begin
         pready = 1'b1; pslverr = cur_err; prdata = cur_rdata;
      end else begin
         pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end
      #2;
      s_ready = req_ready; s_psel = psel; s_penable = penable; s_pwrite = pwrite;
      s_paddr = paddr; s_pwdata = pwdata; s_rsp_valid = rsp_valid; s_rsp_id = rsp_id;
      s_rsp_rnw = rsp_rnw; s_rsp_err = rsp_err; s_rsp_data = rsp_data; s_level = fifo_level;
      if (!reset) begin
         model_step();
         if (s_rsp_valid) n_rsp++;
      end else begin
         mq.delete(); ph = PH_IDLE; mptr = 0; acc = 0; rsp_pend = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      int b = 0;
      req_valid = '0;
      while ((mq.size() != 0 || ph != PH_IDLE || rsp_pend) && b < 800) begin
         tick();
         b++;
      end
      chk("drain_bounded", b < 800, 1);
   endtask

   task automatic wait_rsp(output int en, output bit seen);
      en = 0; seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (s_rsp_valid) seen = 1;
         else if (s_penable) en++;
      end
   endtask

   vec_t tbl[10];
   int   en, accd, maxlvl, gaps;
   bit   seen, started;
   int   rsp_ids[$];

   initial begin
      tbl[0] = '{4'b0000, 4'b0000};
      tbl[1] = '{4'b0100, 4'b0100};
      tbl[2] = '{4'b0101, 4'b0001};
      tbl[3] = '{4'b0101, 4'b0100};
      tbl[4] = '{4'b1111, 4'b1000};
      tbl[5] = '{4'b1111, 4'b0001};
      tbl[6] = '{4'b1010, 4'b0010};
      tbl[7] = '{4'b1010, 4'b1000};
      tbl[8] = '{4'b0110, 4'b0010};
      tbl[9] = '{4'b0001, 4'b0001};

      // reset state
      do_reset();
      tick();
      chk("rst_psel", s_psel, 0);
      chk("rst_penable", s_penable, 0);
      chk("rst_pwrite", s_pwrite, 0);
      chk("rst_paddr", s_paddr, 0);
      chk("rst_pwdata", s_pwdata, 0);
      chk("rst_rsp_valid", s_rsp_valid, 0);
      chk("rst_rsp_id", s_rsp_id, 0);
      chk("rst_rsp_data", s_rsp_data, 0);
      chk("rst_rsp_err", s_rsp_err, 0);
      chk("rst_level", s_level, 0);

      // arbitration table from a freshly reset pointer
      do_reset();
      for (int i = 0; i < 10; i++) begin
         req_valid = tbl[i].valid;
         for (int c = 0; c < NCH; c++) set_req(c, 1'($urandom), $urandom, $urandom);
         tick();
         chk("tbl_ready", s_ready, tbl[i].ready);
      end
      drain();

      // single write, channel 2, zero wait states
      set_req(2, 1'b0, 32'h10, 32'hDEADBEEF);
      req_valid = 4'b0100;
      tick();
      chk("wr_accept", s_ready, 4'b0100);
      req_valid = '0;
      tick();
      chk("wr_t1_psel", s_psel, 0);
      tick();
      chk("wr_t2_setup", {s_psel, s_penable}, 2'b10);
      chk("wr_t2_paddr", s_paddr, 32'h10);
      chk("wr_t2_pwdata", s_pwdata, 32'hDEADBEEF);
      tick();
      chk("wr_t3_access", {s_psel, s_penable}, 2'b11);
      tick();
      chk("wr_t4_rsp_valid", s_rsp_valid, 1);
      chk("wr_t4_rsp_id", s_rsp_id, 2);
      chk("wr_t4_rsp_rnw", s_rsp_rnw, 0);
      chk("wr_t4_rsp_data", s_rsp_data, 0);
      drain();

      // read, channel 0, three wait states
      slave_waits = 3; slave_rdata = 32'h12345678;
      set_req(0, 1'b1, 32'h4, $urandom);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp(en, seen);
      chk("rd_rsp_seen", seen, 1);
      chk("rd_penable_cycles", en, 4);
      chk("rd_rsp_data", s_rsp_data, 32'h12345678);
      drain();

      // timeout on a read that never completes
      slave_waits = -1;
      set_req(3, 1'b1, 32'h40, $urandom);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      wait_rsp(en, seen);
      chk("to_rsp_seen", seen, 1);
      chk("to_access_cycles", en, TIMEOUT);
      chk("to_rsp_err", s_rsp_err, 1);
      chk("to_rsp_data", s_rsp_data, 0);
      drain();

      // read completing with pslverr
      slave_waits = 1; slave_err = 1; slave_rdata = 32'hCAFEF00D;
      set_req(3, 1'b1, 32'h44, $urandom);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      wait_rsp(en, seen);
      chk("err_rsp_seen", seen, 1);
      chk("err_rsp_err", s_rsp_err, 1);
      chk("err_rsp_data", s_rsp_data, 0);
      slave_err = 0;
      drain();

      // stall the slave with 20 requests from channel 1
      slave_waits = -1; accd = 0; maxlvl = 0; n_rsp = 0;
      for (int i = 0; i < 200 && accd < 20; i++) begin
         req_valid = 4'b0010;
         set_req(1, 1'(accd & 1), 32'h100 + 32'(accd * 4), $urandom);
         tick();
         if (s_ready[1]) accd++;
         if (int'(s_level) > maxlvl) maxlvl = int'(s_level);
         if (s_level == 5'd16) chk("full_no_ready", s_ready, 0);
      end
      req_valid = '0;
      chk("stall_accepts", accd, 20);
      chk("stall_max_level", maxlvl, 16);
      slave_waits = 0;
      drain();
      chk("stall_rsp_count", n_rsp, 20);

      // all channels requesting continuously, zero wait states
      do_reset();
      slave_waits = 0; gaps = 0; started = 0;
      rsp_ids.delete();
      for (int i = 0; i < 60; i++) begin
         req_valid = 4'hF;
         for (int c = 0; c < NCH; c++) set_req(c, 1'($urandom), $urandom, $urandom);
         tick();
         if (s_psel) started = 1;
         else if (started) gaps++;
         if (s_rsp_valid) rsp_ids.push_back(int'(s_rsp_id));
      end
      req_valid = '0;
      chk("rr_idle_gaps", gaps, 0);
      for (int i = 0; i < 8; i++)
         chk("rr_rsp_id", (i < rsp_ids.size()) ? rsp_ids[i] : -1, i % NCH);
      drain();

      // reset during ACCESS with three commands queued
      slave_waits = -1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 4'b0010;
         set_req(1, 1'b0, 32'h200 + 32'(i * 4), $urandom);
         tick();
         chk("rm_accept", s_ready, 4'b0010);
      end
      req_valid = '0;
      tick();
      chk("rm_in_access", s_penable, 1);
      chk("rm_queued", s_level, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid = 4'hF;
      tick();
      chk("rm_psel", s_psel, 0);
      chk("rm_level", s_level, 1'b0);
      chk("rm_rsp_valid", s_rsp_valid, 0);
      chk("rm_first_grant", s_ready, 4'b0001);
      req_valid = '0;
      slave_waits = 0;
      drain();

      // randomized traffic against the reference model
      slave_rand = 1;
      for (int i = 0; i < 1500; i++) begin
         req_valid = 4'($urandom);
         for (int c = 0; c < NCH; c++) set_req(c, 1'($urandom), $urandom, $urandom);
         tick();
      end
      drain();
      slave_rand = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_multi_req_engine.md
Name: apb_multi_req_engine

Overview:
- Parametrised successor to the single-requester APB system front-end.
- Accepts read/write requests from NUM_CH independent clients, each carrying its own address and write data.
- Arbitrates between clients round-robin, buffers accepted commands in a DEPTH-entry command FIFO, and drives one APB3 master port with wait-state and PSLVERR support plus a transfer timeout.
- Returns a tagged, one-cycle response per transfer. Sits between client logic and the existing APB slave/memory subsystem.

Parameters:
- NUM_CH, 4, number of client request channels (2..16); CH_W = clog2(NUM_CH).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- DEPTH, 16, command FIFO entries; power of two, at least 2.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready_i; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_rnw_i  in  NUM_CH  per-channel 1=read, 0=write.
- req_addr_i  in  NUM_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_CH*DATA_W  per-channel write data, same packing.
- req_ready_o  out  NUM_CH  one-hot (or zero) accept strobe.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- pready_i, pslverr_i  in  1  APB completion and error.
- prdata_i  in  DATA_W  APB read data.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_id_o  out  CH_W  channel that issued the request.
- rsp_rnw_o, rsp_err_o  out  1  response type and error flag.
- rsp_data_o  out  DATA_W  read data; 0 for writes and errors.
- fifo_level_o  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high, single clock. All outputs are 0, the FSM is IDLE, the FIFO is empty and the round-robin pointer is 0.
- Reset mid-transfer: psel_o/penable_o drop on the reset edge. The in-flight transfer and all buffered commands are discarded with no response.
- Arbitration (combinational):
  - If full=0, grant the first channel with req_valid_i=1 at or after the pointer, searching upward with wrap.
  - req_ready_o has exactly that bit set. If full=1 or no channel is valid, req_ready_o is all-zero.
  - An accept is valid & ready. On accept, the pointer becomes grant+1 (mod NUM_CH); otherwise it holds.
- FIFO entry = {id, rnw, addr, wdata}.
  - Push on accept; pop on FSM load. Simultaneous push and pop leave the level unchanged.
  - full is computed from the registered level (level == DEPTH). A pop in the same cycle does not allow a push into a full FIFO.
  - Pointers wrap modulo DEPTH.
- FSM IDLE: psel_o=0, penable_o=0. If the FIFO is non-empty, pop the head, register paddr/pwrite/pwdata/id, and go to SETUP.
  - pwdata_o is forced to 0 for reads. paddr_o holds its last value while idle.
- FSM SETUP: psel_o=1, penable_o=0, lasting exactly one cycle, then go to ACCESS. Clear the timeout counter.
- FSM ACCESS: psel_o=1, penable_o=1, address/data stable.
  - pready_i=1: complete the transfer.
    - Next cycle: rsp_valid_o=1, rsp_err_o=pslverr_i, rsp_data_o = (read && !pslverr_i) ? prdata_i : 0.
    - If the FIFO is non-empty, pop and go directly to SETUP (back-to-back, no idle cycle); else go to IDLE.
  - pready_i=0: increment the counter. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without pready_i, abort.
    - psel_o drops next cycle.
    - Response: rsp_err_o=1, rsp_data_o=0.
    - Go to IDLE.
- Latency with no contention and zero wait states:
  - Accept at cycle t.
  - FIFO non-empty at t+1, FSM pops.
  - SETUP at t+2, ACCESS at t+3.
  - rsp_valid_o at t+4.
  - Each wait state adds one cycle.
- Response fields are valid only while rsp_valid_o=1. The response interface has no backpressure.
- fifo_level_o is registered and reflects pushes and pops from the previous edge.

Decomposition:
- Package apb_engine_pkg:
  - apb_state_e {ST_IDLE, ST_SETUP, ST_ACCESS}.
  - Localparam helpers for CH_W and level width.
  - APB encoding constants (PWRITE_READ=0, PWRITE_WRITE=1).
- Sub-module apb_rr_arbiter (parameter NUM_CH): valid vector, full and accept in; grant one-hot out; owns the round-robin pointer.
- The FIFO and FSM are inline in the top module.

Test Plan:
- Single write, channel 2, addr 0x10, data 0xDEADBEEF, pready_i=1 in ACCESS → psel_o high t+2..t+3; rsp_valid_o at t+4 with id=2, rnw=0, err=0, data=0.
- Read, channel 0, addr 0x4, slave inserts 3 wait states, prdata_i=0x12345678 → penable_o high for 4 cycles; rsp_data_o=0x12345678 one cycle after pready_i.
- All 4 channels valid continuously, zero wait states → grants cycle 0,1,2,3,0…; back-to-back SETUP/ACCESS with no IDLE gap; rsp_id_o sequence 0,1,2,3.
- Stall pready_i with 20 requests from channel 1 → fifo_level_o saturates at 16; req_ready_o=0 while full; no entry lost or duplicated after release.
- pready_i held 0 with TIMEOUT=16 → abort after 16 ACCESS cycles; rsp_err_o=1, rsp_data_o=0. A separate transfer completing with pslverr_i=1 on a read → rsp_err_o=1, data 0.
- Assert reset during ACCESS with 3 entries queued → psel_o=0 next cycle; level 0; no rsp_valid_o; first post-reset request is granted to channel 0.
